// File: rtl/tt_mvex_lq_buffer.sv
// In-order return buffer from the matrix unit to the load-queue consumer. A beat is visible one cycle after push.
// Backpressure: ready depends only on occupancy, so a full buffer stays not-ready even while a pop happens.
module tt_mvex_lq_buffer #(
    parameter int LQ_DEPTH_LOG2 = 3,
    parameter int VLEN          = 256,
    parameter int DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_mvex_lqvld,
    input  logic [VLEN-1:0]               i_mvex_lqdata,
    input  logic                          i_mvex_lqexc,
    input  logic [LQ_DEPTH_LOG2-1:0]      i_mvex_lqid,
    output logic                          o_mvex_lqrdy,
    output logic                          o_lq_wb_vld,
    output logic [VLEN-1:0]               o_lq_wb_data,
    output logic                          o_lq_wb_exc,
    output logic [LQ_DEPTH_LOG2-1:0]      o_lq_wb_id,
    input  logic                          i_lq_wb_rdy,
    input  logic                          i_flush,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_ovf_err,
    output logic                          o_exc_seen
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [VLEN-1:0]          r_data [DEPTH];
    logic [DEPTH-1:0]         r_exc;
    logic [LQ_DEPTH_LOG2-1:0] r_id   [DEPTH];
    logic [PTR_W-1:0]         r_wptr;
    logic [PTR_W-1:0]         r_rptr;
    logic [CNT_W-1:0]         r_count;
    logic                     r_ovf_err;
    logic                     r_exc_seen;

    logic w_rdy;
    logic w_vld;
    logic w_push;
    logic w_pop;

    assign w_rdy  = (r_count != C_FULL);
    assign w_vld  = (r_count != '0);
    assign w_push = i_mvex_lqvld & w_rdy & ~i_flush;
    assign w_pop  = w_vld & i_lq_wb_rdy & ~i_flush;

    // Storage is intentionally left out of reset; entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= i_mvex_lqdata;
            r_exc[r_wptr]  <= i_mvex_lqexc;
            r_id[r_wptr]   <= i_mvex_lqid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags survive flush; a beat dropped by flush is not an overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_err  <= 1'b0;
            r_exc_seen <= 1'b0;
        end else begin
            if (i_mvex_lqvld & ~w_rdy & ~i_flush) begin
                r_ovf_err <= 1'b1;
            end
            if (w_push & i_mvex_lqexc) begin
                r_exc_seen <= 1'b1;
            end
        end
    end

    assign o_mvex_lqrdy = w_rdy;
    assign o_lq_wb_vld  = w_vld;
    assign o_lq_wb_data = r_data[r_rptr];
    assign o_lq_wb_exc  = r_exc[r_rptr];
    assign o_lq_wb_id   = r_id[r_rptr];
    assign o_count      = r_count;
    assign o_ovf_err    = r_ovf_err;
    assign o_exc_seen   = r_exc_seen;

endmodule

// File: tb/tb_tt_mvex_lq_buffer.sv
// Scoreboard bench for tt_mvex_lq_buffer: stimulus queues expected beats, a negedge monitor checks every pop.
module tb_tt_mvex_lq_buffer;

    localparam int LQW   = 3;
    localparam int VLEN  = 256;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [VLEN-1:0] data;
        logic            exc;
        logic [LQW-1:0]  id;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_mvex_lqvld;
    logic [VLEN-1:0]   i_mvex_lqdata;
    logic              i_mvex_lqexc;
    logic [LQW-1:0]    i_mvex_lqid;
    logic              o_mvex_lqrdy;
    logic              o_lq_wb_vld;
    logic [VLEN-1:0]   o_lq_wb_data;
    logic              o_lq_wb_exc;
    logic [LQW-1:0]    o_lq_wb_id;
    logic              i_lq_wb_rdy;
    logic              i_flush;
    logic [CW-1:0]     o_count;
    logic              o_ovf_err;
    logic              o_exc_seen;

    int total = 0;
    int bad   = 0;
    beat_t sb[$];

    tt_mvex_lq_buffer #(.LQ_DEPTH_LOG2(LQW), .VLEN(VLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .i_mvex_lqvld(i_mvex_lqvld), .i_mvex_lqdata(i_mvex_lqdata),
        .i_mvex_lqexc(i_mvex_lqexc), .i_mvex_lqid(i_mvex_lqid),
        .o_mvex_lqrdy(o_mvex_lqrdy),
        .o_lq_wb_vld(o_lq_wb_vld), .o_lq_wb_data(o_lq_wb_data),
        .o_lq_wb_exc(o_lq_wb_exc), .o_lq_wb_id(o_lq_wb_id),
        .i_lq_wb_rdy(i_lq_wb_rdy), .i_flush(i_flush),
        .o_count(o_count), .o_ovf_err(o_ovf_err), .o_exc_seen(o_exc_seen)
    );

    always #5 clk = ~clk;

    function automatic logic [VLEN-1:0] mkdata(input logic [4:0] salt, input logic [LQW-1:0] id);
        logic [7:0] b;
        b = {salt, id};
        return {(VLEN/8){b}};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one valid beat for the next edge; optionally record it as an expected pop.
    task automatic drive(input logic [LQW-1:0] id, input logic exc, input logic [VLEN-1:0] d,
                         input bit expect_accept);
        beat_t b;
        i_mvex_lqvld  = 1'b1;
        i_mvex_lqid   = id;
        i_mvex_lqexc  = exc;
        i_mvex_lqdata = d;
        if (expect_accept) begin
            b.data = d;
            b.exc  = exc;
            b.id   = id;
            sb.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!reset && !i_flush && o_lq_wb_vld && i_lq_wb_rdy) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got id=%0d expected no beat", o_lq_wb_id);
            end else begin
                e = sb.pop_front();
                if (o_lq_wb_id !== e.id || o_lq_wb_exc !== e.exc || o_lq_wb_data !== e.data) begin
                    bad++;
                    $display("FAIL pop_beat: got id=%0d exc=%0b data[7:0]=%0h expected id=%0d exc=%0b data[7:0]=%0h",
                             o_lq_wb_id, o_lq_wb_exc, o_lq_wb_data[7:0], e.id, e.exc, e.data[7:0]);
                end
            end
        end
    end

    initial begin
        logic [VLEN-1:0] a5;
        a5 = {(VLEN/8){8'hA5}};
        reset = 1'b1; i_mvex_lqvld = 1'b0; i_mvex_lqdata = '0; i_mvex_lqexc = 1'b0;
        i_mvex_lqid = '0; i_lq_wb_rdy = 1'b0; i_flush = 1'b0;
        step(); step();
        reset = 1'b0;

        chk("rst_vld", o_lq_wb_vld, 0);
        chk("rst_rdy", o_mvex_lqrdy, 1);
        chk("rst_count", o_count, 0);
        chk("rst_ovf", o_ovf_err, 0);
        chk("rst_exc_seen", o_exc_seen, 0);

        // Single push, no same-cycle bypass, then pop.
        drive(3'd5, 1'b0, a5, 1);
        chk("no_bypass_vld", o_lq_wb_vld, 0);
        step();
        i_mvex_lqvld = 1'b0;
        chk("single_vld", o_lq_wb_vld, 1);
        chk("single_id", o_lq_wb_id, 5);
        chk("single_data_a5", (o_lq_wb_data == a5) ? 1 : 0, 1);
        chk("single_count", o_count, 1);
        i_lq_wb_rdy = 1'b1;
        step();
        i_lq_wb_rdy = 1'b0;
        chk("single_pop_vld", o_lq_wb_vld, 0);
        chk("single_pop_count", o_count, 0);

        // Flush at count=3 with a concurrent beat: beat dropped, no overflow.
        for (int i = 0; i < 3; i++) begin
            drive(LQW'(i + 1), 1'b0, mkdata(5'd1, LQW'(i + 1)), 0);
            step();
        end
        i_mvex_lqvld = 1'b0;
        chk("pre_flush_count", o_count, 3);
        i_flush = 1'b1;
        drive(3'd4, 1'b0, mkdata(5'd2, 3'd4), 0);
        step();
        i_flush = 1'b0; i_mvex_lqvld = 1'b0;
        chk("flush_count", o_count, 0);
        chk("flush_vld", o_lq_wb_vld, 0);
        chk("flush_rdy", o_mvex_lqrdy, 1);
        chk("flush_no_ovf", o_ovf_err, 0);
        drive(3'd2, 1'b0, mkdata(5'd3, 3'd2), 1);
        step();
        i_mvex_lqvld = 1'b0;
        chk("post_flush_count", o_count, 1);
        chk("post_flush_id", o_lq_wb_id, 2);
        i_lq_wb_rdy = 1'b1;
        step();
        i_lq_wb_rdy = 1'b0;

        // Fill to full, overflow beat, drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(LQW'(i), 1'b0, mkdata(5'd4, LQW'(i)), 1);
            step();
        end
        i_mvex_lqvld = 1'b0;
        chk("full_rdy", o_mvex_lqrdy, 0);
        chk("full_count", o_count, 4);
        chk("full_no_ovf_yet", o_ovf_err, 0);
        drive(3'd7, 1'b0, mkdata(5'd5, 3'd7), 0);
        step();
        i_mvex_lqvld = 1'b0;
        chk("ovf_set", o_ovf_err, 1);
        chk("ovf_count", o_count, 4);
        i_lq_wb_rdy = 1'b1;
        step();
        chk("drain_rdy_after_pop", o_mvex_lqrdy, 1);
        step(); step(); step();
        i_lq_wb_rdy = 1'b0;
        chk("drain_count", o_count, 0);

        // Streaming with pointer wrap.
        i_lq_wb_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(LQW'(i % 8), 1'b0, mkdata(5'd6, LQW'(i % 8)), 1);
            step();
            chk("stream_count", o_count, 1);
        end
        i_mvex_lqvld = 1'b0;
        step();
        i_lq_wb_rdy = 1'b0;
        chk("stream_end_count", o_count, 0);
        chk("stream_ovf_sticky", o_ovf_err, 1);

        // Simultaneous push/pop at count=2.
        for (int i = 0; i < 2; i++) begin
            drive(LQW'(i + 3), 1'b0, mkdata(5'd7, LQW'(i + 3)), 1);
            step();
        end
        chk("pp_pre_count", o_count, 2);
        i_lq_wb_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(LQW'(i + 5), 1'b0, mkdata(5'd8, LQW'(i + 5)), 1);
            step();
            chk("pp_count", o_count, 2);
        end
        i_mvex_lqvld = 1'b0;
        step(); step();
        i_lq_wb_rdy = 1'b0;
        chk("pp_end_count", o_count, 0);

        // Exception beat and sticky exc_seen.
        chk("exc_seen_before", o_exc_seen, 0);
        drive(3'd6, 1'b1, mkdata(5'd9, 3'd6), 1);
        step();
        i_mvex_lqvld = 1'b0;
        chk("exc_head", o_lq_wb_exc, 1);
        chk("exc_head_id", o_lq_wb_id, 6);
        chk("exc_seen_set", o_exc_seen, 1);
        i_lq_wb_rdy = 1'b1;
        step();
        i_lq_wb_rdy = 1'b0;
        chk("exc_seen_after_pop", o_exc_seen, 1);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("exc_seen_after_flush", o_exc_seen, 1);
        chk("ovf_after_flush", o_ovf_err, 1);

        // Mid-stream reset drops entries and clears sticky flags.
        drive(3'd1, 1'b0, mkdata(5'd10, 3'd1), 0);
        step();
        i_mvex_lqvld = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset2_count", o_count, 0);
        chk("reset2_vld", o_lq_wb_vld, 0);
        chk("reset2_exc_seen", o_exc_seen, 0);
        chk("reset2_ovf", o_ovf_err, 0);

        step();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
